// File: rtl/dsram_pkg.sv
// Shared types and helpers for the dsram_mp multi-read-port RAM and its clear controller.
package dsram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Sweep terminates on the word SIZE-1; callers size the result to their pointer width.
    function automatic int unsigned last_ptr(input int unsigned size);
        return size - 32'd1;
    endfunction

endpackage

// File: rtl/dsram_clear_ctrl.sv
// Clear-engine FSM for dsram_mp: sweep pointer, busy/clear_done flags and the array write-port mux controls.
module dsram_clear_ctrl
    import dsram_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int SIZE  = 8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear_req,
    input  logic             i_we,
    input  logic             i_wr_in_range,
    input  logic [WIDTH-1:0] i_wr_addr,
    output logic             o_busy,
    output logic             o_clear_done,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic             o_sel_init
);

    localparam logic [WIDTH-1:0] LAST_PTR = WIDTH'(last_ptr(SIZE));

    state_e           r_state;
    logic [WIDTH-1:0] r_ptr;
    logic             r_busy;
    logic             r_done;

    // Sweep sequencing; busy mirrors CLEAR and is kept as its own flop so the output is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= {WIDTH{1'b0}};
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_state <= IDLE;
                        r_ptr   <= {WIDTH{1'b0}};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= CLEAR;
                        r_ptr   <= r_ptr + WIDTH'(1);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                IDLE: begin
                    r_done <= 1'b0;
                    r_ptr  <= {WIDTH{1'b0}};
                    if (i_clear_req) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= {WIDTH{1'b0}};
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Write-port steering: the sweep owns the array while busy, otherwise in-range external writes.
    always_comb begin
        o_mem_we   = 1'b0;
        o_mem_addr = i_wr_addr;
        if (r_busy) begin
            o_mem_we   = 1'b1;
            o_mem_addr = r_ptr;
        end else begin
            o_mem_we   = i_we & i_wr_in_range;
            o_mem_addr = i_wr_addr;
        end
    end

    assign o_busy       = r_busy;
    assign o_clear_done = r_done;
    assign o_sel_init   = r_busy;

endmodule

// File: rtl/dsram_mp.sv
// Multi-read-port distributed RAM with hardware clear engine and address range protection.
// Optional same-cycle write-through forwarding: define DSRAM_MP_BYPASS_EN.
module dsram_mp
    import dsram_pkg::*;
#(
    parameter int                    WIDTH      = 13,
    parameter int                    SIZE       = 8192,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    RD_PORTS   = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RD_PORTS*WIDTH-1:0]      rd_addr,
    output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
    input  logic                           we,
    input  logic [WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           clear_req,
    output logic                           busy,
    output logic                           clear_done
);

    localparam int                IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [WIDTH:0]    SIZE_W = (WIDTH + 1)'(SIZE);

    logic [DATA_WIDTH-1:0] r_mem [SIZE];

    logic                  w_busy;
    logic                  w_clear_done;
    logic                  w_wr_in_range;
    logic                  w_mem_we;
    logic [WIDTH-1:0]      w_mem_addr;
    logic                  w_sel_init;
    logic [DATA_WIDTH-1:0] w_mem_data;

    assign w_wr_in_range = ({1'b0, wr_addr} < SIZE_W);

    dsram_clear_ctrl #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_clear_ctrl (
        .clk           (clk),
        .rst           (rst),
        .i_clear_req   (clear_req),
        .i_we          (we),
        .i_wr_in_range (w_wr_in_range),
        .i_wr_addr     (wr_addr),
        .o_busy        (w_busy),
        .o_clear_done  (w_clear_done),
        .o_mem_we      (w_mem_we),
        .o_mem_addr    (w_mem_addr),
        .o_sel_init    (w_sel_init)
    );

    assign w_mem_data = w_sel_init ? INIT_VALUE : wr_data;

    // Array write port; contents are deliberately untouched by reset, the sweep initialises them.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr[IDX_W-1:0]] <= w_mem_data;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [WIDTH-1:0]      w_addr;
        logic                  w_in_range;
        logic                  w_fwd;
        logic [DATA_WIDTH-1:0] w_data;

        assign w_addr     = rd_addr[p*WIDTH +: WIDTH];
        assign w_in_range = ({1'b0, w_addr} < SIZE_W);
`ifdef DSRAM_MP_BYPASS_EN
        assign w_fwd      = ~w_busy & we & w_wr_in_range & (w_addr == wr_addr);
`else
        assign w_fwd      = 1'b0;
`endif

        // Busy masks the half-cleared array; the index slice is safe because it is range-gated.
        always_comb begin
            w_data = INIT_VALUE;
            if (w_busy) begin
                w_data = INIT_VALUE;
            end else if (w_fwd) begin
                w_data = wr_data;
            end else if (w_in_range) begin
                w_data = r_mem[w_addr[IDX_W-1:0]];
            end else begin
                w_data = {DATA_WIDTH{1'b0}};
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
    end

    assign busy       = w_busy;
    assign clear_done = w_clear_done;

endmodule

// File: tb/tb_dsram_mp.sv
// Self-checking bench for dsram_mp (SIZE=16, WIDTH=5, RD_PORTS=3, INIT_VALUE=A5A5).
module tb_dsram_mp;

    localparam int          W    = 5;
    localparam int          SZ   = 16;
    localparam int          DW   = 16;
    localparam int          NP   = 3;
    localparam logic [15:0] INIT = 16'hA5A5;

    logic              clk;
    logic              rst;
    logic [NP*W-1:0]   rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic              we;
    logic [W-1:0]      wr_addr;
    logic [DW-1:0]     wr_data;
    logic              clear_req;
    logic              busy;
    logic              clear_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: word store plus a count of sweep edges still to come.
    logic [15:0] m_mem [SZ];
    int          m_left;
    logic        m_done;

    dsram_mp #(
        .WIDTH      (W),
        .SIZE       (SZ),
        .DATA_WIDTH (DW),
        .RD_PORTS   (NP),
        .INIT_VALUE (INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    function automatic logic [4:0] port_addr(input int p);
        return rd_addr[p*W +: W];
    endfunction

    function automatic logic [15:0] exp_rd(input logic [4:0] a);
        if (m_left > 0) return INIT;
`ifdef DSRAM_MP_BYPASS_EN
        if (we === 1'b1 && int'(wr_addr) < SZ && a == wr_addr) return wr_data;
`endif
        if (int'(a) < SZ) return m_mem[a[3:0]];
        return 16'h0000;
    endfunction

    // Advance the model by one posedge using the inputs the DUT is about to sample.
    task automatic model_edge();
        if (rst) begin
            m_left = SZ;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                for (int i = 0; i < SZ; i++) m_mem[i] = INIT;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (we && int'(wr_addr) < SZ) m_mem[wr_addr[3:0]] = wr_data;
            if (clear_req) m_left = SZ;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        rd_addr = {a2, a1, a0};
    endtask

    task automatic compare_all(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s_rd%0d", tag, p), 32'(port_data(p)), 32'(exp_rd(port_addr(p))));
        end
        chk({tag, "_busy"}, 32'(busy), 32'(m_left > 0));
        chk({tag, "_done"}, 32'(clear_done), 32'(m_done));
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [4:0]  ra0, ra1, ra2;
        logic [15:0] e0, e1, e2;
    } vec_t;

    vec_t vt [7];

    initial begin
        int cyc;
        int dcnt;

        rst = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0; rd_addr = '0;
        m_left = SZ; m_done = 1'b0;
        for (int i = 0; i < SZ; i++) m_mem[i] = INIT;

        vt[0] = '{1'b1, 5'd7,  16'h1234, 5'd0,  5'd1,  5'd2,  16'hA5A5, 16'hA5A5, 16'hA5A5};
        vt[1] = '{1'b1, 5'd3,  16'hBEEF, 5'd7,  5'd7,  5'd7,  16'h1234, 16'h1234, 16'h1234};
        vt[2] = '{1'b0, 5'd0,  16'h0000, 5'd7,  5'd3,  5'd7,  16'h1234, 16'hBEEF, 16'h1234};
        vt[3] = '{1'b1, 5'd20, 16'h5555, 5'd20, 5'd15, 5'd0,  16'h0000, 16'hA5A5, 16'hA5A5};
        vt[4] = '{1'b0, 5'd0,  16'h0000, 5'd20, 5'd3,  5'd31, 16'h0000, 16'hBEEF, 16'h0000};
        vt[5] = '{1'b1, 5'd15, 16'h0001, 5'd14, 5'd13, 5'd12, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vt[6] = '{1'b0, 5'd0,  16'h0000, 5'd15, 5'd16, 5'd7,  16'h0001, 16'h0000, 16'h1234};

        // Reset values and release: busy for exactly SIZE edges, then one clear_done pulse.
        #2 rst = 1'b1;
        #1;
        set_rd(5'd0, 5'd9, 5'd30);
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(clear_done), 32'd0);
        for (int p = 0; p < NP; p++) chk($sformatf("rst_rd%0d", p), 32'(port_data(p)), 32'(INIT));
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        dcnt = 0;
        while (busy === 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("rel_busy_cycles", 32'(cyc), 32'd16);
        chk("rel_done_high", 32'(clear_done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (clear_done) dcnt++;
            step();
        end
        chk("rel_done_pulses", 32'(dcnt), 32'd1);
        for (int a = 0; a < SZ; a++) begin
            set_rd(5'(a), 5'((a + 5) % SZ), 5'((a + 11) % SZ));
            #1;
            for (int p = 0; p < NP; p++)
                chk($sformatf("init_a%0d_p%0d", a, p), 32'(port_data(p)), 32'(INIT));
        end

        // Directed write/read/range vectors.
        for (int i = 0; i < 7; i++) begin
            we = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            set_rd(vt[i].ra0, vt[i].ra1, vt[i].ra2);
            #1;
            chk($sformatf("vec%0d_p0", i), 32'(port_data(0)), 32'(vt[i].e0));
            chk($sformatf("vec%0d_p1", i), 32'(port_data(1)), 32'(vt[i].e1));
            chk($sformatf("vec%0d_p2", i), 32'(port_data(2)), 32'(vt[i].e2));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            step();
        end
        we = 1'b0;

        // Same-cycle write/read of addr 4.
        we = 1'b1; wr_addr = 5'd4; wr_data = 16'h0F0F;
        set_rd(5'd7, 5'd4, 5'd3);
        #1;
`ifdef DSRAM_MP_BYPASS_EN
        chk("byp_same_cycle", 32'(port_data(1)), 32'h0F0F);
`else
        chk("byp_same_cycle", 32'(port_data(1)), 32'hA5A5);
`endif
        chk("byp_other_port", 32'(port_data(0)), 32'h1234);
        step();
        we = 1'b0;
        #1;
        chk("byp_after_edge", 32'(port_data(1)), 32'h0F0F);

        // Writes during a requested sweep are ignored.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_busy_accept", 32'(busy), 32'd1);
        cyc = 0;
        dcnt = 0;
        we = 1'b1; wr_addr = 5'd2; wr_data = 16'h7777;
        set_rd(5'd2, 5'd7, 5'd20);
        #1;
        chk("clr_rd_masked", 32'(port_data(1)), 32'(INIT));
        chk("clr_rd_oor_masked", 32'(port_data(2)), 32'(INIT));
        while (busy === 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        we = 1'b0;
        chk("clr_busy_cycles", 32'(cyc), 32'd16);
        chk("clr_done_high", 32'(clear_done), 32'd1);
        #1;
        chk("clr_addr2", 32'(port_data(0)), 32'hA5A5);
        chk("clr_addr7", 32'(port_data(1)), 32'hA5A5);
        step();

        // Reset pulse five cycles into a sweep restarts it.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        m_left = SZ; m_done = 1'b0;
        step();
        rst = 1'b0;
        cyc = 0;
        dcnt = 0;
        while (busy === 1'b1 && cyc < 40) begin
            if (clear_done) dcnt++;
            step();
            cyc++;
        end
        chk("mid_busy_cycles", 32'(cyc), 32'd16);
        for (int i = 0; i < 4; i++) begin
            if (clear_done) dcnt++;
            step();
        end
        chk("mid_done_pulses", 32'(dcnt), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we        = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = 16'($urandom);
            clear_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0)
                set_rd(wr_addr, 5'($urandom_range(0, 31)), wr_addr);
            else
                set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            #1;
            compare_all($sformatf("rnd%0d", i));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsram_mp.md
# dsram_mp

Parametrised multi-read-port distributed RAM: the next generation of the single-read, single-write `dsram` storage primitive. It keeps async reads and synchronous writes, and adds:
- `RD_PORTS` independent read ports;
- a hardware clear engine that sweeps the array to `INIT_VALUE` after reset and on request;
- out-of-range address protection.

It is used wherever several consumers must read one table combinationally in the same cycle.

## Interface
- `WIDTH`, 13, address width in bits
- `SIZE`, 8192, number of words; 2 ≤ SIZE ≤ 2^WIDTH, not necessarily a power of two
- `DATA_WIDTH`, 16, word width
- `RD_PORTS`, 2, number of read ports (≥1)
- `INIT_VALUE`, 0, DATA_WIDTH-bit value written by the clear engine
- `clk`  in  1  single clock; all state changes on posedge
- `rst`  in  1  asynchronous, active-high reset
- `rd_addr`  in  RD_PORTS*WIDTH  packed read addresses; port p at bits [p*WIDTH +: WIDTH]
- `rd_data`  out  RD_PORTS*DATA_WIDTH  packed async read data; port p at [p*DATA_WIDTH +: DATA_WIDTH]
- `we`  in  1  write enable
- `wr_addr`  in  WIDTH  write address
- `wr_data`  in  DATA_WIDTH  write data
- `clear_req`  in  1  request a full-array clear; single-cycle pulse or level
- `busy`  out  1  clear engine active; external writes are ignored
- `clear_done`  out  1  one-cycle pulse when a sweep completes

## Operation
- FSM states: CLEAR and IDLE.
- Reset:
  - While `rst`=1: state=CLEAR, sweep pointer=0, `busy`=1, `clear_done`=0.
  - Array contents are not touched by reset itself.
- CLEAR state:
  - Each posedge writes INIT_VALUE to `mem[ptr]`, then increments ptr.
  - On the edge that writes `ptr==SIZE-1`: state goes to IDLE, `busy` goes to 0, `clear_done` goes to 1 for exactly one cycle.
  - `we` and `clear_req` are ignored; no restart, no queueing.
- IDLE state:
  - If `we`=1 and `wr_addr` < SIZE, `mem[wr_addr]` ← `wr_data` at posedge.
  - If `wr_addr` ≥ SIZE, the write is dropped.
  - If `clear_req`=1 at a posedge: state goes to CLEAR with ptr=0. A `we` on that same edge is still performed, then overwritten by the sweep.
- Reads are combinational, per port:
  - `rd_data[p]` = `mem[rd_addr[p]]` when `rd_addr[p]` < SIZE, else 0.
  - While `busy`=1, every port returns INIT_VALUE regardless of address, so consumers never see a partially cleared array.
- Any number of ports may read the same address; they all return identical data.
- Reset asserted mid-sweep restarts the sweep from address 0 after release.

## Timing
- Read latency is 0 cycles (combinational from `rd_addr`).
- A write is visible on reads 1 cycle later (after the posedge). In the write cycle, reads return old data unless bypass is compiled in.
- After `rst` falls, `busy` stays 1 for exactly SIZE posedges.
- `clear_done` is high during the cycle after the final sweep edge.
- `clear_req` accepted at edge N: `busy`=1 from edge N to edge N+SIZE; `clear_done` is high in the cycle following edge N+SIZE.
- Reset values: `busy`=1, `clear_done`=0, `rd_data`=INIT_VALUE on all ports.

## Configuration
- Macro: `DSRAM_MP_BYPASS_EN`.
- When defined: in IDLE, if `we`=1, `wr_addr` < SIZE and `rd_addr[p]`==`wr_addr`, port p returns `wr_data` combinationally in the same cycle (write-through forwarding).
- When undefined: same-cycle reads return the old contents.
- Forwarding never applies while `busy`=1.

## Structure
- Shared package `dsram_pkg` holds:
  - the state enum (IDLE, CLEAR);
  - a localparam function computing the pointer compare value SIZE-1 at WIDTH bits.
- Sub-module `dsram_clear_ctrl` holds the FSM, the sweep pointer, `busy` and `clear_done`. It outputs the internal write enable, address and data mux select.
- The top level holds the array, the write mux, and the per-port read/range/bypass logic, built in a generate loop.

## Test plan
Run with SIZE=16, WIDTH=5, RD_PORTS=3, INIT_VALUE=16'hA5A5.
- Reset release: `busy`=1 for 16 cycles, then `clear_done` pulses once. All 16 addresses then read A5A5 on all ports.
- Write then read: write 1234 to addr 7, write BEEF to addr 3. Next cycle, ports 0/1/2 read 7/3/7 and return 1234/BEEF/1234.
- Out of range: write 5555 to addr 20, read addr 20 → 0. Addresses 0–15 are unchanged.
- Write during busy: assert `clear_req`, then `we` to addr 2 with 7777 during the sweep. After `clear_done`, addr 2 reads A5A5.
- Mid-sweep reset: pulse `rst` 5 cycles into a sweep. `busy` then lasts 16 cycles from release, and `clear_done` pulses exactly once.
- Bypass: same-cycle `we` to addr 4 with 0F0F while port 1 reads addr 4. Port 1 returns 0F0F with `DSRAM_MP_BYPASS_EN` defined, or the old value without it.
